// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: parity modes, FSM state encoding
// and the sample-tick divisor helper.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rxState_t;

    // Clock cycles per oversample tick, rounded down.
    function automatic int baudDivisor(input int clockFrequency, input int baudRate,
                                       input int oversample);
        return clockFrequency / (baudRate * oversample);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle Tick every DIVISOR clocks, re-phased
// by Restart so a new frame's sampling grid starts at the detected edge.
module uart_baud_tick #(
    parameter int DIVISOR = 10
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Restart,
    output logic Tick
);

    localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

    logic [CW-1:0] count;

    always_ff @(posedge Clk) begin
        if (Reset || Restart) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign Tick = (count == LAST) && !Restart;

endmodule

// File: rtl/uart_rx_config.sv
// Configurable oversampling UART receiver with majority voting, parity/stop
// checking, break detection and a single-entry output register.
module uart_rx_config
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 1_000_000,
    parameter int BAUD_RATE       = 9600,
    parameter int OVERSAMPLE      = 16,
    parameter int DATA_BITS       = 8,
    parameter int PARITY          = 0,
    parameter int STOP_BITS       = 1
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 RxWire,
    output logic [DATA_BITS-1:0] RxData,
    output logic                 RxValid,
    input  logic                 RxReady,
    output logic                 RxParityError,
    output logic                 RxFrameError,
    output logic                 RxOverrun,
    output logic                 RxBreak,
    output logic                 RxBusy
);

    localparam int DIVISOR = baudDivisor(CLOCK_FREQUENCY, BAUD_RATE, OVERSAMPLE);
    localparam int SCW     = $clog2(OVERSAMPLE);
    localparam logic [SCW-1:0] SAMPLE_A      = SCW'(OVERSAMPLE / 2 - 1);
    localparam logic [SCW-1:0] SAMPLE_B      = SCW'(OVERSAMPLE / 2);
    localparam logic [SCW-1:0] SAMPLE_DECIDE = SCW'(OVERSAMPLE / 2 + 1);
    localparam logic [SCW-1:0] SAMPLE_LAST   = SCW'(OVERSAMPLE - 1);
    localparam logic [3:0]     DATA_LAST     = 4'(DATA_BITS - 1);
    localparam logic [3:0]     STOP_LAST     = 4'(STOP_BITS - 1);

    if (DIVISOR < 1) begin : gBadDivisor
        $error("uart_rx_config: CLOCK_FREQUENCY too low for BAUD_RATE*OVERSAMPLE");
    end
    if (OVERSAMPLE < 8 || OVERSAMPLE > 32 || (OVERSAMPLE % 2) != 0 ||
        DATA_BITS < 5 || DATA_BITS > 9 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2) begin : gBadConfig
        $error("uart_rx_config: unsupported parameter combination");
    end

    rxState_t state, nextState;

    logic                 syncA, syncB, prevSync;
    logic                 tick, restart;
    logic [SCW-1:0]       sampleCnt;
    logic                 sampleA, sampleB, vote;
    logic                 atDecide, atBitEnd;
    logic [3:0]           bitCnt;
    logic                 bitClear, bitAdvance;
    logic                 shiftBit, takeParity, takeStop, frameDone;
    logic [DATA_BITS-1:0] shiftReg;
    logic                 dataParity, parityErr, stopErr, allZero, breakHold;
    logic                 breakSeen, accept;

    uart_baud_tick #(.DIVISOR(DIVISOR)) uBaudTick (
        .Clk     (Clk),
        .Reset   (Reset),
        .Restart (restart),
        .Tick    (tick)
    );

    // The third sample is the live synchronized value at the decision tick.
    assign vote      = (sampleA & sampleB) | (sampleA & syncB) | (sampleB & syncB);
    assign atDecide  = tick && (sampleCnt == SAMPLE_DECIDE);
    assign atBitEnd  = tick && (sampleCnt == SAMPLE_LAST);
    assign breakSeen = takeStop && (bitCnt == 4'd0) && allZero && !vote;
    assign accept    = RxValid && RxReady;
    assign RxBusy    = (state != RX_IDLE);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= RX_IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState  = state;
        restart    = 1'b0;
        bitClear   = 1'b0;
        bitAdvance = 1'b0;
        shiftBit   = 1'b0;
        takeParity = 1'b0;
        takeStop   = 1'b0;
        frameDone  = 1'b0;
        case (state)
            RX_IDLE: begin
                if (prevSync && !syncB && !breakHold) begin
                    restart   = 1'b1;
                    bitClear  = 1'b1;
                    nextState = RX_START;
                end
            end
            RX_START: begin
                if (atDecide && vote) begin
                    nextState = RX_IDLE;
                end else if (atBitEnd) begin
                    nextState = RX_DATA;
                end
            end
            RX_DATA: begin
                shiftBit = atDecide;
                if (atBitEnd) begin
                    if (bitCnt == DATA_LAST) begin
                        bitClear  = 1'b1;
                        nextState = (PARITY == PARITY_NONE) ? RX_STOP : RX_PARITY;
                    end else begin
                        bitAdvance = 1'b1;
                    end
                end
            end
            RX_PARITY: begin
                takeParity = atDecide;
                if (atBitEnd) begin
                    nextState = RX_STOP;
                end
            end
            RX_STOP: begin
                takeStop = atDecide;
                // Finish at the last stop bit's centre so the next start edge is never missed.
                if (atDecide && bitCnt == STOP_LAST) begin
                    frameDone = 1'b1;
                    nextState = RX_IDLE;
                end else if (atBitEnd) begin
                    bitAdvance = 1'b1;
                end
            end
            default: nextState = RX_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            syncA      <= 1'b1;
            syncB      <= 1'b1;
            prevSync   <= 1'b1;
            sampleCnt  <= '0;
            sampleA    <= 1'b1;
            sampleB    <= 1'b1;
            bitCnt     <= '0;
            shiftReg   <= '0;
            dataParity <= 1'b0;
            parityErr  <= 1'b0;
            stopErr    <= 1'b0;
            allZero    <= 1'b0;
            breakHold  <= 1'b0;
            RxBreak    <= 1'b0;
        end else begin
            syncA    <= RxWire;
            syncB    <= syncA;
            prevSync <= syncB;
            RxBreak  <= breakSeen;

            if (restart) begin
                sampleCnt <= '0;
            end else if (tick) begin
                sampleCnt <= (sampleCnt == SAMPLE_LAST) ? '0 : sampleCnt + 1'b1;
            end
            if (tick && sampleCnt == SAMPLE_A) sampleA <= syncB;
            if (tick && sampleCnt == SAMPLE_B) sampleB <= syncB;

            if (bitClear) begin
                bitCnt <= '0;
            end else if (bitAdvance) begin
                bitCnt <= bitCnt + 1'b1;
            end

            if (restart) begin
                shiftReg   <= '0;
                dataParity <= 1'b0;
                parityErr  <= 1'b0;
                stopErr    <= 1'b0;
                allZero    <= 1'b1;
            end
            if (shiftBit) begin
                shiftReg   <= {vote, shiftReg[DATA_BITS-1:1]};
                dataParity <= dataParity ^ vote;
                if (vote) allZero <= 1'b0;
            end
            if (takeParity) begin
                parityErr <= (PARITY == PARITY_EVEN) ? (dataParity ^ vote) : ~(dataParity ^ vote);
                if (vote) allZero <= 1'b0;
            end
            if (takeStop && !vote) stopErr <= 1'b1;

            // After a break the line is still low; wait for it to go high before re-arming.
            if (breakSeen) begin
                breakHold <= 1'b1;
            end else if (syncB) begin
                breakHold <= 1'b0;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            RxData        <= '0;
            RxValid       <= 1'b0;
            RxParityError <= 1'b0;
            RxFrameError  <= 1'b0;
            RxOverrun     <= 1'b0;
        end else begin
            if (frameDone && (!RxValid || RxReady)) begin
                RxData        <= shiftReg;
                RxValid       <= 1'b1;
                RxParityError <= parityErr;
                RxFrameError  <= stopErr | !vote;
            end else if (accept) begin
                RxData        <= '0;
                RxValid       <= 1'b0;
                RxParityError <= 1'b0;
                RxFrameError  <= 1'b0;
            end

            if (accept) begin
                RxOverrun <= 1'b0;
            end else if (frameDone && RxValid) begin
                RxOverrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_config.sv
// Testbench for uart_rx_config: three instances (8N1, 8E1, 8N2) driven with
// directed and random frames, checked against a frame-level reference model.
module tb_uart_rx_config;

    localparam int CLK_HZ   = 1_536_000;
    localparam int BAUD     = 9600;
    localparam int OS       = 16;
    localparam int BIT_CLKS = 160;

    typedef struct packed {
        logic [7:0] data;
        logic       parityErr;
        logic       frameErr;
    } expect_t;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       RxReady;
    logic       line   [3];
    logic [7:0] rxData [3];
    logic       rxValid[3];
    logic       rxPe   [3];
    logic       rxFe   [3];
    logic       rxOvr  [3];
    logic       rxBrk  [3];
    logic       rxBusy [3];

    int vectors     = 0;
    int miscompares = 0;

    always #5 Clk = ~Clk;

    uart_rx_config #(.CLOCK_FREQUENCY(CLK_HZ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
                     .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dutN1 (
        .Clk(Clk), .Reset(Reset), .RxWire(line[0]), .RxData(rxData[0]), .RxValid(rxValid[0]),
        .RxReady(RxReady), .RxParityError(rxPe[0]), .RxFrameError(rxFe[0]),
        .RxOverrun(rxOvr[0]), .RxBreak(rxBrk[0]), .RxBusy(rxBusy[0]));

    uart_rx_config #(.CLOCK_FREQUENCY(CLK_HZ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
                     .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dutE1 (
        .Clk(Clk), .Reset(Reset), .RxWire(line[1]), .RxData(rxData[1]), .RxValid(rxValid[1]),
        .RxReady(RxReady), .RxParityError(rxPe[1]), .RxFrameError(rxFe[1]),
        .RxOverrun(rxOvr[1]), .RxBreak(rxBrk[1]), .RxBusy(rxBusy[1]));

    uart_rx_config #(.CLOCK_FREQUENCY(CLK_HZ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
                     .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) dutN2 (
        .Clk(Clk), .Reset(Reset), .RxWire(line[2]), .RxData(rxData[2]), .RxValid(rxValid[2]),
        .RxReady(RxReady), .RxParityError(rxPe[2]), .RxFrameError(rxFe[2]),
        .RxOverrun(rxOvr[2]), .RxBreak(rxBrk[2]), .RxBusy(rxBusy[2]));

    // Expected frame outcome from the bits put on the line.
    function automatic expect_t referenceFrame(input logic [7:0] data, input int parityMode,
                                               input logic parityBit, input logic stop1,
                                               input logic stop2, input int nStop);
        expect_t e;
        int      ones;
        ones        = $countones(data) + ((parityMode != 0 && parityBit) ? 1 : 0);
        e.data      = data;
        e.parityErr = (parityMode == 1) ? (ones % 2 == 1) :
                      (parityMode == 2) ? (ones % 2 == 0) : 1'b0;
        e.frameErr  = !stop1 || (nStop == 2 && !stop2);
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(negedge Clk);
    endtask

    // Drives one full frame on a line; riseAt is the cycle (from the start
    // bit) at which RxValid was first seen high, or -1.
    task automatic applyStimulus(input int idx, input logic [7:0] data, input int parityMode,
                                 input logic parityBit, input logic stop1, input logic stop2,
                                 input int nStop, output int riseAt);
        logic bits[$];
        int   cyc;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(data[i]);
        if (parityMode != 0) bits.push_back(parityBit);
        bits.push_back(stop1);
        if (nStop == 2) bits.push_back(stop2);
        riseAt = -1;
        cyc    = 0;
        foreach (bits[b]) begin
            line[idx] = bits[b];
            repeat (BIT_CLKS) begin
                @(negedge Clk);
                cyc++;
                if (riseAt < 0 && rxValid[idx]) riseAt = cyc;
            end
        end
        line[idx] = 1'b1;
    endtask

    task automatic checkDelivered(input int idx, input expect_t e, input string tag);
        checkOutput({tag, "_valid"}, rxValid[idx], 1'b1);
        checkOutput({tag, "_data"},  rxData[idx],  e.data);
        checkOutput({tag, "_perr"},  rxPe[idx],    e.parityErr);
        checkOutput({tag, "_ferr"},  rxFe[idx],    e.frameErr);
        RxReady = 1'b1;
        @(negedge Clk);
        RxReady = 1'b0;
        checkOutput({tag, "_cleared"}, rxValid[idx], 1'b0);
    endtask

    initial begin
        int         riseAt;
        logic [7:0] rb;
        logic       pb, s1, s2;
        expect_t    ex;
        int         brkCount, framesSeen;
        logic [7:0] brkData;
        logic       brkFe, found;

        Reset   = 1'b1;
        RxReady = 1'b0;
        for (int i = 0; i < 3; i++) line[i] = 1'b1;
        idle(5);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("reset%0d_valid", i), rxValid[i], 1'b0);
            checkOutput($sformatf("reset%0d_data", i),  rxData[i],  8'h00);
            checkOutput($sformatf("reset%0d_flags", i),
                        {rxPe[i], rxFe[i], rxOvr[i], rxBrk[i], rxBusy[i]}, 5'b0);
        end
        Reset = 1'b0;
        idle(20);

        // 8N1 0xA5 with latency bound relative to the stop-bit centre (cycle 1520).
        applyStimulus(0, 8'hA5, 0, 1'b0, 1'b1, 1'b1, 1, riseAt);
        checkOutput("a5_latency", (riseAt > 1440 && riseAt <= 1520 + BIT_CLKS + 8), 1'b1);
        checkDelivered(0, referenceFrame(8'hA5, 0, 1'b0, 1'b1, 1'b1, 1), "a5");

        for (int n = 0; n < 5; n++) begin
            rb = 8'($urandom);
            idle($urandom_range(20, 200));
            applyStimulus(0, rb, 0, 1'b0, 1'b1, 1'b1, 1, riseAt);
            checkDelivered(0, referenceFrame(rb, 0, 1'b0, 1'b1, 1'b1, 1), $sformatf("n1_rand%0d", n));
        end

        // 8E1 parity: 0x07 has odd weight, so parity bit 0 is wrong and 1 is right.
        applyStimulus(1, 8'h07, 1, 1'b0, 1'b1, 1'b1, 1, riseAt);
        checkDelivered(1, referenceFrame(8'h07, 1, 1'b0, 1'b1, 1'b1, 1), "e1_07p0");
        idle(30);
        applyStimulus(1, 8'h07, 1, 1'b1, 1'b1, 1'b1, 1, riseAt);
        checkDelivered(1, referenceFrame(8'h07, 1, 1'b1, 1'b1, 1'b1, 1), "e1_07p1");
        for (int n = 0; n < 4; n++) begin
            rb = 8'($urandom);
            pb = 1'($urandom_range(0, 1));
            idle($urandom_range(20, 200));
            applyStimulus(1, rb, 1, pb, 1'b1, 1'b1, 1, riseAt);
            checkDelivered(1, referenceFrame(rb, 1, pb, 1'b1, 1'b1, 1), $sformatf("e1_rand%0d", n));
        end

        // 8N2 with a low second stop bit, then random stop patterns.
        applyStimulus(2, 8'h3C, 0, 1'b0, 1'b1, 1'b0, 2, riseAt);
        idle(20);
        checkDelivered(2, referenceFrame(8'h3C, 0, 1'b0, 1'b1, 1'b0, 2), "n2_3c");
        for (int n = 0; n < 4; n++) begin
            rb = 8'($urandom_range(1, 255));
            s1 = 1'($urandom_range(0, 1));
            s2 = 1'($urandom_range(0, 1));
            idle($urandom_range(20, 200));
            applyStimulus(2, rb, 0, 1'b0, s1, s2, 2, riseAt);
            idle(20);
            checkDelivered(2, referenceFrame(rb, 0, 1'b0, s1, s2, 2), $sformatf("n2_rand%0d", n));
        end

        // Short glitch on an idle line must be rejected as a false start.
        idle(50);
        line[0] = 1'b0;
        idle(40);
        line[0] = 1'b1;
        checkOutput("glitch_busy", rxBusy[0], 1'b1);
        found = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge Clk);
            if (!rxBusy[0]) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("glitch_idle_within_100", found, 1'b1);
        idle(400);
        checkOutput("glitch_no_valid", rxValid[0], 1'b0);

        // Back-to-back frames with no consumer: second frame overruns.
        applyStimulus(0, 8'h11, 0, 1'b0, 1'b1, 1'b1, 1, riseAt);
        applyStimulus(0, 8'h22, 0, 1'b0, 1'b1, 1'b1, 1, riseAt);
        idle(50);
        checkOutput("ovr_valid", rxValid[0], 1'b1);
        checkOutput("ovr_data",  rxData[0],  8'h11);
        checkOutput("ovr_flag",  rxOvr[0],   1'b1);
        RxReady = 1'b1;
        @(negedge Clk);
        RxReady = 1'b0;
        checkOutput("ovr_accept_valid", rxValid[0], 1'b0);
        checkOutput("ovr_accept_flag",  rxOvr[0],   1'b0);

        // Break: line low for 12 bit times, consuming any frame that appears.
        idle(100);
        line[0]    = 1'b0;
        brkCount   = 0;
        framesSeen = 0;
        brkData    = 8'hFF;
        brkFe      = 1'b0;
        for (int c = 0; c < 12 * BIT_CLKS; c++) begin
            @(negedge Clk);
            if (rxBrk[0]) brkCount++;
            if (RxReady) begin
                RxReady = 1'b0;
            end else if (rxValid[0]) begin
                framesSeen++;
                brkData = rxData[0];
                brkFe   = rxFe[0];
                RxReady = 1'b1;
            end
        end
        RxReady = 1'b0;
        checkOutput("brk_pulses", brkCount,   1);
        checkOutput("brk_frames", framesSeen, 1);
        checkOutput("brk_data",   brkData,    8'h00);
        checkOutput("brk_ferr",   brkFe,      1'b1);
        line[0] = 1'b1;
        idle(300);
        checkOutput("brk_idle_valid", rxValid[0], 1'b0);
        checkOutput("brk_idle_busy",  rxBusy[0],  1'b0);
        rb = 8'($urandom);
        applyStimulus(0, rb, 0, 1'b0, 1'b1, 1'b1, 1, riseAt);
        checkDelivered(0, referenceFrame(rb, 0, 1'b0, 1'b1, 1'b1, 1), "brk_rearm");

        // Reset in data bit 4 while an earlier frame is still held.
        idle(50);
        applyStimulus(0, 8'h5A, 0, 1'b0, 1'b1, 1'b1, 1, riseAt);
        idle(30);
        rb = 8'($urandom);
        line[0] = 1'b0;
        idle(BIT_CLKS);
        for (int i = 0; i < 4; i++) begin
            line[0] = rb[i];
            idle(BIT_CLKS);
        end
        line[0] = rb[4];
        idle(BIT_CLKS / 2);
        checkOutput("rst_pre_busy",  rxBusy[0],  1'b1);
        checkOutput("rst_pre_valid", rxValid[0], 1'b1);
        Reset = 1'b1;
        idle(2);
        line[0] = 1'b1;
        checkOutput("rst_valid", rxValid[0], 1'b0);
        checkOutput("rst_data",  rxData[0],  8'h00);
        checkOutput("rst_flags", {rxPe[0], rxFe[0], rxOvr[0], rxBrk[0], rxBusy[0]}, 5'b0);
        idle(2);
        Reset = 1'b0;
        idle(2 * BIT_CLKS * 10);
        checkOutput("rst_no_valid", rxValid[0], 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx_config.md
UART_RX_CONFIG -- requirements
Module: uart_rx_config

Interface
REQ-001 Parameter CLOCK_FREQUENCY, default 1_000_000: input clock rate, Hz.
REQ-002 Parameter BAUD_RATE, default 9600: line bit rate, baud.
REQ-003 Parameter OVERSAMPLE, default 16: sample ticks per bit; even, range 8..32.
REQ-004 Parameter DATA_BITS, default 8: payload bits per frame, range 5..9, LSB first on the line.
REQ-005 Parameter PARITY, default 0: parity mode; 0 none, 1 even, 2 odd.
REQ-006 Parameter STOP_BITS, default 1: stop bits checked, 1 or 2.
REQ-007 Clk  input  1  single clock; all logic on posedge.
REQ-008 Reset  input  1  synchronous, active-high reset.
REQ-009 RxWire  input  1  asynchronous serial line; idle high.
REQ-010 RxData  output  DATA_BITS  received payload, valid while RxValid=1.
REQ-011 RxValid  output  1  a frame is held in the output register.
REQ-012 RxReady  input  1  consumer accepts the held frame when RxValid=1.
REQ-013 RxParityError  output  1  held frame failed parity; qualifies RxData.
REQ-014 RxFrameError  output  1  held frame had a low stop bit; qualifies RxData.
REQ-015 RxOverrun  output  1  sticky: a completed frame was dropped because the output register was full.
REQ-016 RxBreak  output  1  one-cycle pulse on break-frame detection.
REQ-017 RxBusy  output  1  receiver FSM is not IDLE.

Function
REQ-018 RxWire SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value, adding 2 cycles of latency.
REQ-019 Sample tick period SHALL be floor(CLOCK_FREQUENCY/(BAUD_RATE*OVERSAMPLE)) Clk cycles; a divisor below 1 SHALL be an elaboration error.
REQ-020 The tick divider and the per-bit sample counter (0..OVERSAMPLE-1) SHALL restart on the cycle a falling edge is detected in IDLE.
REQ-021 FSM states: IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY=0.
REQ-022 Each bit value SHALL be the majority of the samples at counts OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1; the decision is made at count OVERSAMPLE/2+1.
REQ-023 START: a voted 1 SHALL be a false start and return to IDLE with no flag or output change; a voted 0 SHALL proceed to DATA at the bit end (count OVERSAMPLE-1).
REQ-024 DATA SHALL shift in DATA_BITS bits LSB-first, then go to PARITY or STOP at the bit end.
REQ-025 PARITY: even mode SHALL flag an error when the XOR of data and parity bit is 1; odd mode SHALL flag an error when it is 0.
REQ-026 STOP: each stop bit voted 0 SHALL set the frame error; with STOP_BITS=2 both bits SHALL be checked.
REQ-027 The frame SHALL complete at the decision point of the last stop bit, not at its bit end, and the FSM SHALL return to IDLE that cycle so back-to-back frames resynchronize.
REQ-028 On completion the data and error bits SHALL load into the output register; RxValid SHALL rise on the next cycle.
REQ-029 The held frame SHALL be cleared when RxValid=1 and RxReady=1; RxReady while RxValid=0 SHALL be ignored.
REQ-030 Completion while RxValid=1 and RxReady=0: the new frame SHALL be dropped, the held frame kept, and RxOverrun set.
REQ-031 Completion in the same cycle as an accept SHALL load the new frame without setting RxOverrun.
REQ-032 RxOverrun SHALL stay set until the next accepted handshake or Reset.
REQ-033 Break: all data bits, any parity bit and the first stop bit sampled 0 SHALL pulse RxBreak for one cycle. The frame SHALL still be delivered with RxFrameError=1, and IDLE SHALL not re-arm until RxWire has been sampled high.

Reset
REQ-034 With Reset=1 at a Clk edge: FSM to IDLE, counters and divider to 0, synchronizer flops to 1, RxData to 0, and all status outputs to 0.
REQ-035 Reset asserted mid-frame or mid-handshake SHALL discard the partial frame and the held frame, with no flag asserted.

Structure
REQ-036 Shared package uart_pkg: parity-mode constants (PARITY_NONE/EVEN/ODD), FSM state encodings, and a divisor helper function.
REQ-037 One sub-module, uart_baud_tick: parametrised divider with synchronous restart input and single-cycle tick output.

Verification (CLOCK_FREQUENCY=1_536_000, BAUD_RATE=9600, OVERSAMPLE=16 -> 160 clocks per bit)
REQ-038 8N1, byte 0xA5 -> RxData=0xA5, RxValid high with both error flags 0, rising within 1 bit time + 8 cycles of the stop-bit midpoint.
REQ-039 8E1, byte 0x07 with parity bit 0 -> RxData=0x07 and RxParityError=1; repeating with parity bit 1 -> RxParityError=0.
REQ-040 8N2, 0x3C with a low second stop bit -> RxFrameError=1. Separately, a 40-clock low glitch on an idle line -> no RxValid and RxBusy back to 0 within 100 cycles.
REQ-041 8N1, 0x11 then 0x22 back-to-back with RxReady=0 -> RxData=0x11 and RxOverrun=1. Then RxReady=1 for one cycle -> RxValid=0 and RxOverrun=0.
REQ-042 Line held low for 12 bit times -> exactly one RxBreak pulse and RxData=0x00 with RxFrameError=1, then no further frames until the line returns high. Reset asserted at data bit 4 of a frame -> all outputs 0 and no RxValid.
